hash_table_top: RTL and testbench



---
 rtl/hash_table_pkg.sv | 58 +++++
 rtl/ht_res_if.sv | 17 +
 rtl/ht_task_if.sv | 15 +
 rtl/hash_table_empty_ptr_storage.sv | 34 +++
 rtl/hash_table_top.sv | 213 +++++++++++++++++++++
 tb/tb_hash_table_top.sv | 229 ++++++++++++++++++++++
 6 files changed

// File: rtl/hash_table_pkg.sv
// Shared widths, command/result encodings, entry structs and the bucket hash
// for the chained key/value hash table.
package hash_table;

  localparam int KEY_WIDTH        = 32;
  localparam int VALUE_WIDTH      = 16;
  localparam int BUCKET_WIDTH     = 8;
  localparam int TABLE_ADDR_WIDTH = 8;
  localparam int BUCKETS          = 1 << BUCKET_WIDTH;
  localparam int NODES            = 1 << TABLE_ADDR_WIDTH;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    INSERT = 2'd1,
    DELETE = 2'd2
  } ht_cmd_t;

  typedef enum logic [2:0] {
    SEARCH_FOUND,
    SEARCH_NOT_SUCCESS_NO_ENTRY,
    INSERT_SUCCESS_SAME_KEY,
    INSERT_NOT_SUCCESS_TABLE_IS_FULL,
    INSERT_SUCCESS,
    DELETE_SUCCESS,
    DELETE_NOT_SUCCESS_NO_ENTRY
  } ht_rescode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ_HEAD,
    S_READ_NODE,
    S_CMP,
    S_UPDATE,
    S_RESULT
  } ht_state_t;

  typedef struct packed {
    logic [TABLE_ADDR_WIDTH-1:0] ptr;
    logic                        ptr_val;
  } head_entry_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]        key;
    logic [VALUE_WIDTH-1:0]      value;
    logic [TABLE_ADDR_WIDTH-1:0] next_ptr;
    logic                        next_val;
  } node_entry_t;

  // XOR-fold of the key into bucket-sized slices.
  function automatic logic [BUCKET_WIDTH-1:0] ht_hash(input logic [KEY_WIDTH-1:0] key);
    logic [BUCKET_WIDTH-1:0] h;
    h = '0;
    for (int i = 0; i < KEY_WIDTH / BUCKET_WIDTH; i++)
      h ^= key[i*BUCKET_WIDTH +: BUCKET_WIDTH];
    return h;
  endfunction

endpackage

// File: rtl/ht_res_if.sv
// Result channel: one response per accepted task, held until consumed.
interface ht_res_if
  import hash_table::*;
(
  input logic clk
);
  ht_cmd_t                 cmd;
  logic [KEY_WIDTH-1:0]    key;
  logic [VALUE_WIDTH-1:0]  value;
  ht_rescode_t             rescode;
  logic [BUCKET_WIDTH-1:0] bucket;
  logic                    valid;
  logic                    ready;

  modport master (input clk, ready, output cmd, key, value, rescode, bucket, valid);
  modport slave  (input clk, cmd, key, value, rescode, bucket, valid, output ready);
endinterface

// File: rtl/ht_task_if.sv
// Task request channel: one SEARCH/INSERT/DELETE command per valid/ready beat.
interface ht_task_if
  import hash_table::*;
(
  input logic clk
);
  logic [KEY_WIDTH-1:0]   key;
  logic [VALUE_WIDTH-1:0] value;
  ht_cmd_t                cmd;
  logic                   valid;
  logic                   ready;

  modport master (input clk, ready, output key, value, cmd, valid);
  modport slave  (input clk, key, value, cmd, valid, output ready);
endinterface

// File: rtl/hash_table_empty_ptr_storage.sv
// Node free tracker: one used bit per node, lowest free index offered for allocation.
module empty_ptr_storage
  import hash_table::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc,
  input  logic                        free,
  input  logic [TABLE_ADDR_WIDTH-1:0] free_idx,
  output logic [TABLE_ADDR_WIDTH-1:0] empty_idx,
  output logic                        full
);

  logic [NODES-1:0] used;

  always_ff @(posedge clk) begin
    if (rst)
      used <= '0;
    else if (alloc)
      used[empty_idx] <= 1'b1;
    else if (free)
      used[free_idx] <= 1'b0;
  end

  // NOTE: the default assignment at the top keeps this combinational block latch-free.
  always_comb begin
    empty_idx = '0;
    for (int i = NODES - 1; i >= 0; i--)
      if (!used[i]) empty_idx = TABLE_ADDR_WIDTH'(i);
  end

  assign full = &used;

endmodule

// File: rtl/hash_table_top.sv
// Chained key/value hash table: head-pointer table, node table and free tracker,
// walked by a single-command FSM with 1-cycle-latency RAM reads.
module hash_table_top
  import hash_table::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  ht_task_if.slave ht_task_in,
  ht_res_if.master ht_res_out
);

  ht_state_t state, next_state;

  logic [KEY_WIDTH-1:0]        key_q;
  logic [VALUE_WIDTH-1:0]      value_q;
  ht_cmd_t                     cmd_q;
  logic [BUCKET_WIDTH-1:0]     bucket_q;
  logic [TABLE_ADDR_WIDTH-1:0] cur_ptr, prev_ptr;
  logic                        prev_val, first, found;

  head_entry_t head_rd, sel, head_wdata;
  node_entry_t node_rd;

  logic [KEY_WIDTH-1:0]        key_mem      [NODES];
  logic [VALUE_WIDTH-1:0]      value_mem    [NODES];
  logic [TABLE_ADDR_WIDTH:0]   link_mem     [NODES];
  logic [TABLE_ADDR_WIDTH-1:0] head_ptr_mem [BUCKETS];
  logic [BUCKETS-1:0]          head_val;

  logic                        task_ready, res_valid, accept, res_fire, key_match;
  logic                        node_rd_en, head_we, key_we, value_we, link_we, alloc, free, full;
  logic [TABLE_ADDR_WIDTH-1:0] node_waddr, empty_idx;
  logic [TABLE_ADDR_WIDTH:0]   link_wdata;

  ht_cmd_t                 res_cmd;
  logic [KEY_WIDTH-1:0]    res_key;
  logic [VALUE_WIDTH-1:0]  res_value;
  ht_rescode_t             res_code;
  logic [BUCKET_WIDTH-1:0] res_bucket;

  assign accept    = ht_task_in.valid & task_ready;
  assign res_fire  = res_valid & ht_res_out.ready;
  assign key_match = (node_rd.key == key_q);
  // The first hop follows the head entry, later hops follow the node just compared.
  assign sel = first ? head_rd : '{ptr: node_rd.next_ptr, ptr_val: node_rd.next_val};

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:      if (accept) next_state = S_READ_HEAD;
      S_READ_HEAD: next_state = S_READ_NODE;
      S_READ_NODE: begin
        if (sel.ptr_val)                  next_state = S_CMP;
        else if (cmd_q == INSERT && !full) next_state = S_UPDATE;
        else                              next_state = S_RESULT;
      end
      S_CMP: begin
        if (!key_match)           next_state = S_READ_NODE;
        else if (cmd_q == SEARCH) next_state = S_RESULT;
        else                      next_state = S_UPDATE;
      end
      S_UPDATE:    next_state = S_RESULT;
      S_RESULT:    if (res_fire) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_comb begin
    task_ready = (state == S_IDLE) && !rst_i;
    res_valid  = (state == S_RESULT);
    node_rd_en = (state == S_READ_NODE) && sel.ptr_val;
    head_we    = 1'b0;
    head_wdata = '0;
    key_we     = 1'b0;
    value_we   = 1'b0;
    link_we    = 1'b0;
    node_waddr = cur_ptr;
    link_wdata = '0;
    alloc      = 1'b0;
    free       = 1'b0;
    if (state == S_UPDATE) begin
      if (cmd_q == INSERT && found) begin
        value_we = 1'b1;
      end else if (cmd_q == INSERT) begin
        key_we     = 1'b1;
        value_we   = 1'b1;
        link_we    = 1'b1;
        node_waddr = empty_idx;
        link_wdata = {head_rd.ptr, head_rd.ptr_val};
        head_we    = 1'b1;
        head_wdata = '{ptr: empty_idx, ptr_val: 1'b1};
        alloc      = 1'b1;
      end else begin
        free = 1'b1;
        if (prev_val) begin
          link_we    = 1'b1;
          node_waddr = prev_ptr;
          link_wdata = {node_rd.next_ptr, node_rd.next_val};
        end else begin
          head_we    = 1'b1;
          head_wdata = '{ptr: node_rd.next_ptr, ptr_val: node_rd.next_val};
        end
      end
    end
  end

  // NOTE: the RAM arrays are not reset; head_val and the used bits alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (state == S_READ_HEAD) begin
      head_rd.ptr     <= head_ptr_mem[bucket_q];
      head_rd.ptr_val <= head_val[bucket_q];
    end
    if (node_rd_en) begin
      node_rd.key                        <= key_mem[sel.ptr];
      node_rd.value                      <= value_mem[sel.ptr];
      {node_rd.next_ptr, node_rd.next_val} <= link_mem[sel.ptr];
    end
    if (key_we)   key_mem[node_waddr]   <= key_q;
    if (value_we) value_mem[node_waddr] <= value_q;
    if (link_we)  link_mem[node_waddr]  <= link_wdata;
    if (head_we)  head_ptr_mem[bucket_q] <= head_wdata.ptr;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_val   <= '0;
      key_q      <= '0;
      value_q    <= '0;
      cmd_q      <= SEARCH;
      bucket_q   <= '0;
      cur_ptr    <= '0;
      prev_ptr   <= '0;
      prev_val   <= 1'b0;
      first      <= 1'b0;
      found      <= 1'b0;
      res_cmd    <= SEARCH;
      res_key    <= '0;
      res_value  <= '0;
      res_code   <= ht_rescode_t'(0);
      res_bucket <= '0;
    end else begin
      if (accept) begin
        key_q    <= ht_task_in.key;
        value_q  <= ht_task_in.value;
        cmd_q    <= ht_task_in.cmd;
        bucket_q <= ht_hash(ht_task_in.key);
      end
      if (state == S_READ_HEAD) begin
        first <= 1'b1;
        found <= 1'b0;
      end
      if (node_rd_en) begin
        cur_ptr  <= sel.ptr;
        prev_ptr <= cur_ptr;
        prev_val <= !first;
        first    <= 1'b0;
      end
      if (state == S_CMP && key_match) found <= 1'b1;
      if (head_we) head_val[bucket_q] <= head_wdata.ptr_val;

      if (next_state == S_RESULT && state != S_RESULT) begin
        res_cmd    <= cmd_q;
        res_key    <= key_q;
        res_bucket <= bucket_q;
        res_value  <= value_q;
        unique case (state)
          S_CMP: begin
            res_code  <= SEARCH_FOUND;
            res_value <= node_rd.value;
          end
          S_READ_NODE: begin
            unique case (cmd_q)
              SEARCH: begin
                res_code  <= SEARCH_NOT_SUCCESS_NO_ENTRY;
                res_value <= '0;
              end
              INSERT:  res_code <= INSERT_NOT_SUCCESS_TABLE_IS_FULL;
              default: res_code <= DELETE_NOT_SUCCESS_NO_ENTRY;
            endcase
          end
          default: begin
            if (cmd_q == INSERT) res_code <= found ? INSERT_SUCCESS_SAME_KEY : INSERT_SUCCESS;
            else                 res_code <= DELETE_SUCCESS;
          end
        endcase
      end
    end
  end

  assign ht_task_in.ready   = task_ready;
  assign ht_res_out.valid   = res_valid;
  assign ht_res_out.cmd     = res_cmd;
  assign ht_res_out.key     = res_key;
  assign ht_res_out.value   = res_value;
  assign ht_res_out.rescode = res_code;
  assign ht_res_out.bucket  = res_bucket;

  empty_ptr_storage u_empty_ptr_storage (
    .clk       (clk_i),
    .rst       (rst_i),
    .alloc     (alloc),
    .free      (free),
    .free_idx  (cur_ptr),
    .empty_idx (empty_idx),
    .full      (full)
  );

endmodule

// File: tb/tb_hash_table_top.sv
// Directed bench for hash_table_top: tasks push expected results into a
// scoreboard queue, a monitor pops and compares each consumed result.
module tb_hash_table_top;
  import hash_table::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ht_task_if task_if (clk);
  ht_res_if  res_if  (clk);

  hash_table_top dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ht_task_in (task_if),
    .ht_res_out (res_if)
  );

  typedef struct {
    ht_cmd_t     cmd;
    logic [31:0] key;
    logic [15:0] value;
    ht_rescode_t rc;
    logic [7:0]  bucket;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] tb_hash(input logic [31:0] k);
    return k[31:24] ^ k[23:16] ^ k[15:8] ^ k[7:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res_if.valid && res_if.ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'(res_if.key), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("res_rescode", 64'(res_if.rescode), 64'(e.rc));
        check("res_value",   64'(res_if.value),   64'(e.value));
        check("res_key",     64'(res_if.key),     64'(e.key));
        check("res_cmd",     64'(res_if.cmd),     64'(e.cmd));
        check("res_bucket",  64'(res_if.bucket),  64'(e.bucket));
      end
    end
  end

  // Drives one task, waits for acceptance, then scrambles the inputs to prove capture.
  task automatic send(input ht_cmd_t c, input logic [31:0] k, input logic [15:0] v,
                      input ht_rescode_t rc, input logic [15:0] ev);
    int n;
    n = 0;
    @(negedge clk);
    task_if.cmd   = c;
    task_if.key   = k;
    task_if.value = v;
    task_if.valid = 1'b1;
    while (!task_if.ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!task_if.ready) begin
      check("task_accept_timeout", 64'd0, 64'd1);
      task_if.valid = 1'b0;
      return;
    end
    sb.push_back('{cmd: c, key: k, value: ev, rc: rc, bucket: tb_hash(k)});
    @(posedge clk);
    #1;
    task_if.valid = 1'b0;
    task_if.key   = ~k;
    task_if.value = ~v;
    task_if.cmd   = SEARCH;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_task_ready", 64'(task_if.ready), 64'd0);
    check("reset_res_valid",  64'(res_if.valid),  64'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] snap_value;
    logic [31:0] snap_key;
    ht_rescode_t snap_rc;
    bit          stable, ready_low, seen_valid;
    int          n;

    task_if.valid = 1'b0;
    task_if.key   = '0;
    task_if.value = '0;
    task_if.cmd   = SEARCH;
    res_if.ready  = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_task_ready", 64'(task_if.ready),   64'd0);
    check("reset_res_valid",  64'(res_if.valid),    64'd0);
    check("reset_res_value",  64'(res_if.value),    64'd0);
    check("reset_res_key",    64'(res_if.key),      64'd0);
    check("reset_res_code",   64'(res_if.rescode),  64'd0);
    rst = 1'b0;

    // Basic insert / delete / search.
    send(INSERT, 32'h0100_0000, 16'h1234, INSERT_SUCCESS, 16'h1234);
    send(INSERT, 32'h0100_0001, 16'h1235, INSERT_SUCCESS, 16'h1235);
    send(DELETE, 32'h0100_0001, 16'h0000, DELETE_SUCCESS, 16'h0000);
    send(SEARCH, 32'h0100_0001, 16'h0000, SEARCH_NOT_SUCCESS_NO_ENTRY, 16'h0000);
    send(SEARCH, 32'h0100_0000, 16'h0000, SEARCH_FOUND, 16'h1234);
    drain();

    // Collision chain in bucket 0x01: head 0x100 -> 0x001 -> 0x01000000.
    do_reset();
    send(INSERT, 32'h0100_0000, 16'h1111, INSERT_SUCCESS, 16'h1111);
    send(INSERT, 32'h0000_0001, 16'h2222, INSERT_SUCCESS, 16'h2222);
    send(INSERT, 32'h0000_0100, 16'h3333, INSERT_SUCCESS, 16'h3333);
    send(DELETE, 32'h0000_0001, 16'h0007, DELETE_SUCCESS, 16'h0007);
    send(SEARCH, 32'h0100_0000, 16'h0000, SEARCH_FOUND, 16'h1111);
    send(SEARCH, 32'h0000_0100, 16'h0000, SEARCH_FOUND, 16'h3333);
    send(DELETE, 32'h0000_0001, 16'h0008, DELETE_NOT_SUCCESS_NO_ENTRY, 16'h0008);
    send(DELETE, 32'h0000_0100, 16'h0009, DELETE_SUCCESS, 16'h0009);
    send(SEARCH, 32'h0100_0000, 16'h0000, SEARCH_FOUND, 16'h1111);
    send(SEARCH, 32'h0000_0100, 16'h0000, SEARCH_NOT_SUCCESS_NO_ENTRY, 16'h0000);

    // Overwrite existing key.
    send(INSERT, 32'h0100_0000, 16'hABCD, INSERT_SUCCESS_SAME_KEY, 16'hABCD);
    send(SEARCH, 32'h0100_0000, 16'h0000, SEARCH_FOUND, 16'hABCD);
    drain();

    // Fill every node with one key per bucket, then probe the full condition.
    do_reset();
    for (int i = 0; i < NODES; i++)
      send(INSERT, 32'(i), 16'h5A00 ^ 16'(i), INSERT_SUCCESS, 16'h5A00 ^ 16'(i));
    send(INSERT, 32'h0000_0100, 16'hBEEF, INSERT_NOT_SUCCESS_TABLE_IS_FULL, 16'hBEEF);
    send(INSERT, 32'h0000_0007, 16'h7777, INSERT_SUCCESS_SAME_KEY, 16'h7777);
    send(SEARCH, 32'h0000_00FF, 16'h0000, SEARCH_FOUND, 16'h5AFF);
    send(DELETE, 32'h0000_0005, 16'h0000, DELETE_SUCCESS, 16'h0000);
    send(INSERT, 32'h0000_0100, 16'hBEEF, INSERT_SUCCESS, 16'hBEEF);
    send(SEARCH, 32'h0000_0100, 16'h0000, SEARCH_FOUND, 16'hBEEF);
    send(SEARCH, 32'h0000_0001, 16'h0000, SEARCH_FOUND, 16'h5A01);
    drain();

    // Result back-pressure: fields stay put and no new task is accepted.
    @(negedge clk);
    res_if.ready = 1'b0;
    send(SEARCH, 32'h0000_0007, 16'h0000, SEARCH_FOUND, 16'h7777);
    n = 0;
    while (!res_if.valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_valid_seen", 64'(res_if.valid), 64'd1);
    snap_value = res_if.value;
    snap_key   = res_if.key;
    snap_rc    = res_if.rescode;
    stable     = 1'b1;
    ready_low  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!res_if.valid || res_if.value !== snap_value || res_if.key !== snap_key ||
          res_if.rescode !== snap_rc) stable = 1'b0;
      if (task_if.ready) ready_low = 1'b0;
    end
    check("hold_result_stable", 64'(stable),    64'd1);
    check("hold_task_ready_low", 64'(ready_low), 64'd1);
    res_if.ready = 1'b1;
    drain();

    // Reset in the middle of a chain walk aborts the task and empties the table.
    @(negedge clk);
    task_if.cmd   = SEARCH;
    task_if.key   = 32'h0000_0001;
    task_if.value = '0;
    task_if.valid = 1'b1;
    n = 0;
    while (!task_if.ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_task_accepted", 64'(task_if.ready), 64'd1);
    @(posedge clk);
    #1;
    task_if.valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_if.valid) seen_valid = 1'b1;
    end
    check("abort_no_result", 64'(seen_valid), 64'd0);
    send(SEARCH, 32'h0000_0001, 16'h0000, SEARCH_NOT_SUCCESS_NO_ENTRY, 16'h0000);
    send(SEARCH, 32'h0000_0100, 16'h0000, SEARCH_NOT_SUCCESS_NO_ENTRY, 16'h0000);
    drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
